// File: rtl/instr_encoder.sv
// Symbolic-instruction encoder: packs requests into MIPS words and loads them into instruction memory.
// Optional macro ENC_ILLEGAL_TRAP_EN: illegal classes are consumed without a write instead of being written as NOP.
module instr_encoder #(
   parameter int unsigned DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned CW        = 7
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    in_class,
   input  logic [4:0]    in_rs,
   input  logic [4:0]    in_rt,
   input  logic [4:0]    in_rd,
   input  logic [4:0]    in_shamt,
   input  logic [5:0]    in_funct,
   input  logic [15:0]   in_imm,
   input  logic [25:0]   in_target,
   input  logic          in_last,
   output logic          im_we,
   output logic [31:0]   im_addr,
   output logic [31:0]   im_wdata,
   output logic [CW-1:0] word_count,
   output logic          busy,
   output logic          done,
   output logic          err
);

`ifdef ENC_ILLEGAL_TRAP_EN
   localparam bit TRAP_ILLEGAL = 1'b1;
`else
   localparam bit TRAP_ILLEGAL = 1'b0;
`endif

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_JR    = 6'b001001;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state;
   logic [31:0] addr;

   logic [31:0]   enc_word_c;
   logic          illegal_c;
   logic          accept_c;
   logic          write_c;
   logic          finish_c;
   logic [CW-1:0] sess_cnt_c;
   logic [31:0]   sess_addr_c;
   logic [CW-1:0] cnt_next_c;

   // Opcode map shared with the main decoder
   always_comb begin
      enc_word_c = 32'h0000_0000;
      illegal_c  = 1'b0;
      case (in_class)
         4'd0:    enc_word_c = {OP_RTYPE, in_rs, in_rt, in_rd, in_shamt, in_funct};
         4'd1:    enc_word_c = {OP_LW,   in_rs, in_rt, in_imm};
         4'd2:    enc_word_c = {OP_SW,   in_rs, in_rt, in_imm};
         4'd3:    enc_word_c = {OP_ADDI, in_rs, in_rt, in_imm};
         4'd4:    enc_word_c = {OP_ANDI, in_rs, in_rt, in_imm};
         4'd5:    enc_word_c = {OP_ORI,  in_rs, in_rt, in_imm};
         4'd6:    enc_word_c = {OP_BEQ,  in_rs, in_rt, in_imm};
         4'd7:    enc_word_c = {OP_BNE,  in_rs, in_rt, in_imm};
         4'd8:    enc_word_c = {OP_JAL,  in_target};
         4'd9:    enc_word_c = {OP_JR,   in_rs, 21'b0};
         4'd10:   enc_word_c = {OP_J,    in_target};
         default: illegal_c  = 1'b1;
      endcase
   end

   // A start seen in RUN rebases the session before any same-cycle request is applied
   always_comb begin
      sess_cnt_c  = start ? CW'(0) : word_count;
      sess_addr_c = start ? BASE_ADDR : addr;
      accept_c    = (state == RUN) && in_valid && in_ready;
      write_c     = accept_c && !(illegal_c && TRAP_ILLEGAL);
      cnt_next_c  = sess_cnt_c + (write_c ? CW'(1) : CW'(0));
      finish_c    = accept_c && (in_last || (cnt_next_c == CW'(DEPTH)));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         addr       <= BASE_ADDR;
         in_ready   <= 1'b0;
         im_we      <= 1'b0;
         im_addr    <= BASE_ADDR;
         im_wdata   <= 32'h0000_0000;
         word_count <= CW'(0);
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         im_we <= write_c;
         if (write_c) begin
            im_wdata <= enc_word_c;
            im_addr  <= sess_addr_c;
         end
         if (start || accept_c) begin
            addr       <= sess_addr_c + (write_c ? 32'd4 : 32'd0);
            word_count <= cnt_next_c;
            err        <= (start ? 1'b0 : err) | (accept_c && illegal_c);
         end
         if (finish_c) begin
            state    <= DONE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
         end else if (start || state == RUN) begin
            state    <= RUN;
            in_ready <= (cnt_next_c < CW'(DEPTH));
            busy     <= 1'b1;
            done     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed table, corner sequences and a randomized model run.
module tb_instr_encoder;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = 3;
`ifdef ENC_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, start, in_valid, in_ready, in_last;
   logic [3:0]    in_class;
   logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
   logic [5:0]    in_funct;
   logic [15:0]   in_imm;
   logic [25:0]   in_target;
   logic          im_we, busy, done, err;
   logic [31:0]   im_addr, im_wdata;
   logic [CW-1:0] word_count;

   int vec_cnt = 0;
   int err_cnt = 0;

   instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000), .CW(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
      .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
      .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .word_count(word_count),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        first;
      logic [3:0]  cls;
      logic [4:0]  rs, rt, rd, sh;
      logic [5:0]  fn;
      logic [15:0] imm;
      logic [25:0] tgt;
      logic        last;
      logic [31:0] word;
   } vec_t;

   vec_t tbl[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_req(input logic [3:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                          input logic [15:0] imm, input logic [25:0] tgt, input logic last);
      in_valid = 1'b1; in_class = cls; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
      in_funct = fn; in_imm = imm; in_target = tgt; in_last = last;
   endtask

   task automatic idle_in();
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Reference encoding straight from the opcode table
   function automatic logic [31:0] ref_word(input logic [3:0] cls, input logic [4:0] rs,
         input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
         input logic [15:0] imm, input logic [25:0] tgt);
      logic [5:0] op [11];
      op = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h04, 6'h05, 6'h03, 6'h09, 6'h02};
      if (cls == 4'd0)                     return {op[0], rs, rt, rd, sh, fn};
      if (cls >= 4'd1 && cls <= 4'd7)      return {op[cls], rs, rt, imm};
      if (cls == 4'd8 || cls == 4'd10)     return {op[cls], tgt};
      if (cls == 4'd9)                     return {op[9], rs, 21'b0};
      return 32'h0000_0000;
   endfunction

   initial begin
      int idx;
      int cnt;
      bit ended, errm, acc, wr, ill;
      logic [31:0] exp_w;

      tbl[0] = '{1, 4'd3, 5'd0, 5'd8,  5'd0,  5'd0, 6'h00, 16'h0005, 26'h0,  1, 32'h2008_0005};
      tbl[1] = '{1, 4'd1, 5'd8, 5'd9,  5'd0,  5'd0, 6'h00, 16'h0004, 26'h0,  0, 32'h8D09_0004};
      tbl[2] = '{0, 4'd0, 5'd8, 5'd9,  5'd10, 5'd0, 6'h20, 16'h0000, 26'h0,  0, 32'h0109_5020};
      tbl[3] = '{0, 4'd6, 5'd8, 5'd9,  5'd0,  5'd0, 6'h00, 16'hFFFE, 26'h0,  1, 32'h1109_FFFE};
      tbl[4] = '{1, 4'd10, 5'd0, 5'd0, 5'd0,  5'd0, 6'h00, 16'h0000, 26'h10, 0, 32'h0800_0010};
      tbl[5] = '{0, 4'd8, 5'd0, 5'd0,  5'd0,  5'd0, 6'h00, 16'h0000, 26'h10, 0, 32'h0C00_0010};
      tbl[6] = '{0, 4'd9, 5'd31, 5'd0, 5'd0,  5'd0, 6'h00, 16'h0000, 26'h0,  1, 32'h27E0_0000};

      reset = 1'b1; start = 1'b0;
      set_req(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
      idle_in();
      tick(); tick();
      reset = 1'b0;
      chk("rst_ready", {31'b0, in_ready}, 0);
      chk("rst_we", {31'b0, im_we}, 0);
      chk("rst_addr", im_addr, 0);
      chk("rst_wdata", im_wdata, 0);
      chk("rst_count", 32'(word_count), 0);
      chk("rst_busy_done_err", {29'b0, busy, done, err}, 0);

      // Requests in IDLE are ignored
      set_req(4'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd7, 26'd0, 1'b0);
      tick(); tick();
      chk("idle_no_we", {31'b0, im_we}, 0);
      idle_in();

      // Directed table, back-to-back within each session
      idx = 0;
      for (int i = 0; i < 7; i++) begin
         if (tbl[i].first) begin
            do_start();
            idx = 0;
            chk("start_ready_busy", {30'b0, in_ready, busy}, 32'd3);
         end
         set_req(tbl[i].cls, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].sh, tbl[i].fn,
                 tbl[i].imm, tbl[i].tgt, tbl[i].last);
         tick();
         chk("tbl_we", {31'b0, im_we}, 1);
         chk("tbl_addr", im_addr, 32'(idx * 4));
         chk("tbl_wdata", im_wdata, tbl[i].word);
         chk("tbl_count", 32'(word_count), 32'(idx + 1));
         idx++;
         if (tbl[i].last) begin
            idle_in();
            tick();
            chk("tbl_done_busy_ready", {29'b0, done, busy, in_ready}, 32'd4);
            chk("tbl_after_we", {31'b0, im_we}, 0);
         end
      end

      // Fill to capacity without in_last, then a 5th request is held off
      do_start();
      for (int i = 0; i < 4; i++) begin
         set_req(4'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'(i), 26'd0, 1'b0);
         tick();
         chk("fill_we", {31'b0, im_we}, 1);
      end
      chk("fill_last_addr", im_addr, 32'h0000_000C);
      chk("fill_done_ready", {30'b0, done, in_ready}, 32'd2);
      tick();
      chk("fill_5th_no_we", {31'b0, im_we}, 0);
      chk("fill_5th_count", 32'(word_count), 32'd4);
      idle_in();

      // Illegal class 12
      do_start();
      set_req(4'd12, 5'd3, 5'd4, 5'd5, 5'd6, 6'd7, 16'h1234, 26'h0, 1'b0);
      tick();
      idle_in();
      chk("ill_err", {31'b0, err}, 1);
      if (TRAP) begin
         chk("ill_trap_we", {31'b0, im_we}, 0);
         chk("ill_trap_count", 32'(word_count), 0);
      end else begin
         chk("ill_nop_we", {31'b0, im_we}, 1);
         chk("ill_nop_wdata", im_wdata, 0);
         chk("ill_nop_count", 32'(word_count), 1);
      end
      tick();
      chk("ill_err_sticky", {31'b0, err}, 1);
      chk("ill_busy", {31'b0, busy}, 1);

      // Reset on the same cycle a request is accepted
      do_start();
      set_req(4'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h00AA, 26'd0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rstacc_we", {31'b0, im_we}, 0);
      chk("rstacc_addr", im_addr, 0);
      chk("rstacc_wdata", im_wdata, 0);
      chk("rstacc_count", 32'(word_count), 0);
      chk("rstacc_flags", {28'b0, in_ready, busy, done, err}, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rstacc_ignored", {30'b0, im_we, in_ready}, 0);
      end
      idle_in();

      // Randomized sessions against the reference model
      for (int s = 0; s < 40; s++) begin
         do_start();
         cnt = 0; ended = 0; errm = 0;
         for (int c = 0; c < 30 && !ended; c++) begin
            set_req(($urandom_range(0, 9) == 0) ? 4'(11 + $urandom_range(0, 4)) : 4'($urandom_range(0, 10)),
                    5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
                    16'($urandom), 26'($urandom), ($urandom_range(0, 5) == 0));
            in_valid = ($urandom_range(0, 3) != 0);
            chk("rnd_ready", {31'b0, in_ready}, 1);
            acc   = in_valid;
            ill   = (in_class > 4'd10);
            wr    = acc && !(ill && TRAP);
            exp_w = ref_word(in_class, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target);
            tick();
            chk("rnd_we", {31'b0, im_we}, {31'b0, wr});
            if (wr) begin
               chk("rnd_addr", im_addr, 32'(cnt * 4));
               chk("rnd_wdata", im_wdata, exp_w);
               cnt++;
            end
            if (acc && ill) errm = 1;
            if (acc && (in_last || cnt == DEPTH)) ended = 1;
            chk("rnd_count", 32'(word_count), 32'(cnt));
            chk("rnd_flags", {29'b0, err, done, busy}, {29'b0, errm, ended, !ended});
         end
         idle_in();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
